// File: rtl/regfile_access_ctrl_pkg.sv
// Shared definitions for the register-file access controller: default widths,
// ALU op encodings and controller FSM state encodings.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 2;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_MOV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RD   = 2'b01,
        S_EX   = 2'b10,
        S_WB   = 2'b11
    } state_e;

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// Command handshake plus register-file read/write bus seen by the controller.
// master = the controller; slave = command source and register file together.
interface regfile_access_ctrl_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_src1;
    logic [ADDR_W-1:0] cmd_src2;
    logic [ADDR_W-1:0] cmd_dst;
    logic [ADDR_W-1:0] rdreg1;
    logic [ADDR_W-1:0] rdreg2;
    logic [DATA_W-1:0] rdData1;
    logic [DATA_W-1:0] rdData2;
    logic [ADDR_W-1:0] wrreg;
    logic [DATA_W-1:0] wrData;
    logic              write;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;

    modport master (
        input  cmd_valid, cmd_op, cmd_src1, cmd_src2, cmd_dst, rdData1, rdData2,
        output cmd_ready, rdreg1, rdreg2, wrreg, wrData, write, busy, done, result
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_src1, cmd_src2, cmd_dst, rdData1, rdData2,
        input  cmd_ready, rdreg1, rdreg2, wrreg, wrData, write, busy, done, result
    );

endinterface

// File: rtl/regfile_access_ctrl_alu.sv
// Two-operand ALU shared by the access controller and the instruction decoder.
// Arithmetic wraps modulo 2**DATA_W; MOV passes the first operand through.
module regfile_alu
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  op_e               op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    // Select the operation result for the current op.
    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_MOV:  y = a;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Register-file access controller: accepts one command, reads two sources,
// computes an ALU result and writes it back (IDLE -> RD -> EX -> WB, 4 cycles).
module regfile_access_ctrl
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                  clock,
    input  logic                  reset,
    regfile_access_ctrl_if.master bus
);

    state_e            state;
    state_e            state_next;
    logic              transfer;
    logic              write_c;
    logic              busy_c;

    op_e               op_q;
    logic [ADDR_W-1:0] src1_q;
    logic [ADDR_W-1:0] src2_q;
    logic [ADDR_W-1:0] dst_q;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] res_q;
    logic [DATA_W-1:0] alu_y;
    logic [ADDR_W-1:0] wrreg_q;
    logic [DATA_W-1:0] result_q;
    logic              done_q;

    // Ready is gated by reset so nothing can transfer while reset is asserted.
    assign bus.cmd_ready = (state == S_IDLE) && !reset;
    assign transfer      = bus.cmd_valid && bus.cmd_ready;

    regfile_alu #(.DATA_W(DATA_W)) u_alu (
        .op (op_q),
        .a  (op_a),
        .b  (op_b),
        .y  (alu_y)
    );

    // State register; reset aborts any command in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state sequencing and decoded write/busy (write follows state, so it drops with reset).
    always_comb begin
        state_next = S_IDLE;
        write_c    = 1'b0;
        busy_c     = 1'b1;
        case (state)
            S_IDLE: begin
                busy_c     = 1'b0;
                state_next = transfer ? S_RD : S_IDLE;
            end
            S_RD:    state_next = S_EX;
            S_EX:    state_next = S_WB;
            S_WB: begin
                write_c    = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Latch the command on transfer; src fields directly drive the read selects.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q   <= OP_ADD;
            src1_q <= '0;
            src2_q <= '0;
            dst_q  <= '0;
        end else if (transfer) begin
            op_q   <= op_e'(bus.cmd_op);
            src1_q <= bus.cmd_src1;
            src2_q <= bus.cmd_src2;
            dst_q  <= bus.cmd_dst;
        end
    end

    // Capture operands in RD, result and write select in EX.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_a    <= '0;
            op_b    <= '0;
            res_q   <= '0;
            wrreg_q <= '0;
        end else begin
            if (state == S_RD) begin
                op_a <= bus.rdData1;
                op_b <= bus.rdData2;
            end
            if (state == S_EX) begin
                res_q   <= alu_y;
                wrreg_q <= dst_q;
            end
        end
    end

    // Commit-side outputs: result holds until the next write-back, done pulses once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state == S_WB);
            if (state == S_WB) result_q <= res_q;
        end
    end

    assign bus.rdreg1 = src1_q;
    assign bus.rdreg2 = src2_q;
    assign bus.wrreg  = wrreg_q;
    assign bus.wrData = res_q;
    assign bus.write  = write_c;
    assign bus.busy   = busy_c;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: controller plus a 4x32 register file with a
// backdoor preload port, checked against a behavioural array model.
module tb_regfile_access_ctrl;
    import regfile_pkg::*;

    logic        clock;
    logic        reset;
    logic        bd_we;
    logic [1:0]  bd_addr;
    logic [31:0] bd_data;
    logic [31:0] rf [4];
    logic [31:0] model [4];

    int errors;
    int checks;
    int write_count;
    int accept_count;

    regfile_access_ctrl_if #(.DATA_W(32), .ADDR_W(2)) bus ();

    regfile_access_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register file: combinational reads, backdoor has priority over the controller write.
    always @(posedge clock) begin
        if (bd_we)          rf[bd_addr]   <= bd_data;
        else if (bus.write) rf[bus.wrreg] <= bus.wrData;
    end
    assign bus.rdData1 = rf[bus.rdreg1];
    assign bus.rdData2 = rf[bus.rdreg2];

    // Count regfile writes and accepted commands.
    always @(posedge clock) begin
        if (bus.write && !reset)                        write_count++;
        if (bus.cmd_valid && bus.cmd_ready && !reset)   accept_count++;
    end

    // Hard stop if the run hangs.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] refAlu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic preload(input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] v3);
        logic [31:0] vals [4];
        vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
        for (int i = 0; i < 4; i++) begin
            bd_we   = 1'b1;
            bd_addr = 2'(i);
            bd_data = vals[i];
            model[i] = vals[i];
            @(negedge clock);
        end
        bd_we = 1'b0;
    endtask

    // Present a command at a negedge and return 1 unit after the transferring edge.
    task automatic applyStimulus(input logic [1:0] op, input logic [1:0] s1, input logic [1:0] s2,
                                 input logic [1:0] d, input bit hold_valid);
        bit ok;
        ok            = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_src1  = s1;
        bus.cmd_src2  = s2;
        bus.cmd_dst   = d;
        for (int t = 0; t < 20; t++) begin
            if (bus.cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL handshake_timeout: observed=no_ready expected=ready");
            bus.cmd_valid = 1'b0;
        end else begin
            @(posedge clock);
            #1;
            if (!hold_valid) bus.cmd_valid = 1'b0;
        end
    endtask

    // Run one command and check every phase against the model; ends at the done-cycle negedge.
    task automatic runCmd(input logic [1:0] op, input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] d);
        logic [31:0] expv;
        int          w0;
        expv = refAlu(op, model[s1], model[s2]);
        w0   = write_count;
        applyStimulus(op, s1, s2, d, 1'b0);
        @(negedge clock);
        checkOutput("rd_rdreg1", 32'(bus.rdreg1), 32'(s1));
        checkOutput("rd_rdreg2", 32'(bus.rdreg2), 32'(s2));
        checkOutput("rd_write", 32'(bus.write), 32'd0);
        checkOutput("rd_busy", 32'(bus.busy), 32'd1);
        checkOutput("rd_done", 32'(bus.done), 32'd0);
        @(negedge clock);
        checkOutput("ex_write", 32'(bus.write), 32'd0);
        checkOutput("ex_ready", 32'(bus.cmd_ready), 32'd0);
        @(negedge clock);
        checkOutput("wb_write", 32'(bus.write), 32'd1);
        checkOutput("wb_wrreg", 32'(bus.wrreg), 32'(d));
        checkOutput("wb_wrdata", bus.wrData, expv);
        @(negedge clock);
        checkOutput("done_pulse", 32'(bus.done), 32'd1);
        checkOutput("done_result", bus.result, expv);
        checkOutput("done_write", 32'(bus.write), 32'd0);
        checkOutput("done_rf", rf[d], expv);
        checkOutput("done_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("one_write", 32'(write_count - w0), 32'd1);
        model[d] = expv;
    endtask

    initial begin
        int w0;
        int a0;
        errors        = 0;
        checks        = 0;
        write_count   = 0;
        accept_count  = 0;
        bd_we         = 1'b0;
        bd_addr       = '0;
        bd_data       = '0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_src1  = '0;
        bus.cmd_src2  = '0;
        bus.cmd_dst   = '0;
        reset         = 1'b1;

        // Reset state
        @(negedge clock);
        checkOutput("rst_ready", 32'(bus.cmd_ready), 32'd0);
        checkOutput("rst_write", 32'(bus.write), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        checkOutput("rst_result", bus.result, 32'd0);
        checkOutput("rst_wrdata", bus.wrData, 32'd0);
        checkOutput("rst_wrreg", 32'(bus.wrreg), 32'd0);
        checkOutput("rst_rdreg1", 32'(bus.rdreg1), 32'd0);
        checkOutput("rst_rdreg2", 32'(bus.rdreg2), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("post_rst_ready", 32'(bus.cmd_ready), 32'd1);

        // ADD R2 <- R0 + R1
        $display("[TB] directed ADD");
        preload(32'd5, 32'd3, 32'd0, 32'hFFFF_FFFF);
        runCmd(OP_ADD, 2'd0, 2'd1, 2'd2);
        checkOutput("t1_r2", rf[2], 32'd8);
        @(negedge clock);
        checkOutput("t1_done_one_cycle", 32'(bus.done), 32'd0);
        checkOutput("t1_result_held", bus.result, 32'd8);

        // SUB wraps, AND, MOV
        $display("[TB] directed SUB/AND/MOV");
        preload(32'd5, 32'd3, 32'd0, 32'hFFFF_FFFF);
        runCmd(OP_SUB, 2'd2, 2'd1, 2'd2);
        checkOutput("t2_sub", rf[2], 32'hFFFF_FFFD);
        runCmd(OP_AND, 2'd3, 2'd1, 2'd0);
        checkOutput("t2_and", rf[0], 32'd3);
        runCmd(OP_MOV, 2'd3, 2'd0, 2'd1);
        checkOutput("t2_mov", rf[1], 32'hFFFF_FFFF);
        @(negedge clock);

        // Back-to-back with valid held high; second transfers in the done cycle
        $display("[TB] back-to-back");
        preload(32'd5, 32'd3, 32'd0, 32'hFFFF_FFFF);
        applyStimulus(OP_ADD, 2'd0, 2'd1, 2'd2, 1'b1);
        bus.cmd_op   = OP_ADD;
        bus.cmd_src1 = 2'd2;
        bus.cmd_src2 = 2'd2;
        bus.cmd_dst  = 2'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checkOutput("b2b_not_ready", 32'(bus.cmd_ready), 32'd0);
        end
        @(negedge clock);
        checkOutput("b2b_ready_in_done", 32'(bus.cmd_ready), 32'd1);
        checkOutput("b2b_done1", 32'(bus.done), 32'd1);
        checkOutput("b2b_r2", rf[2], 32'd8);
        @(posedge clock);
        #1;
        bus.cmd_valid = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("b2b_wb2_wrdata", bus.wrData, 32'd16);
        @(negedge clock);
        checkOutput("b2b_done2", 32'(bus.done), 32'd1);
        checkOutput("b2b_result2", bus.result, 32'd16);
        checkOutput("b2b_r3", rf[3], 32'd16);
        @(negedge clock);

        // Valid pulse while busy must not transfer
        $display("[TB] valid while busy");
        preload(32'd5, 32'd3, 32'd0, 32'hFFFF_FFFF);
        w0 = write_count;
        a0 = accept_count;
        applyStimulus(OP_ADD, 2'd0, 2'd1, 2'd2, 1'b0);
        @(negedge clock);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_SUB;
        bus.cmd_src1  = 2'd3;
        bus.cmd_src2  = 2'd3;
        bus.cmd_dst   = 2'd0;
        checkOutput("busy_ready_rd", 32'(bus.cmd_ready), 32'd0);
        @(negedge clock);
        checkOutput("busy_ready_ex", 32'(bus.cmd_ready), 32'd0);
        bus.cmd_valid = 1'b0;
        repeat (5) @(negedge clock);
        checkOutput("busy_r2", rf[2], 32'd8);
        checkOutput("busy_r0_untouched", rf[0], 32'd5);
        checkOutput("busy_writes", 32'(write_count - w0), 32'd1);
        checkOutput("busy_accepts", 32'(accept_count - a0), 32'd1);
        checkOutput("busy_idle", 32'(bus.busy), 32'd0);

        // Async reset during WB
        $display("[TB] reset in WB");
        preload(32'd5, 32'd3, 32'd0, 32'hFFFF_FFFF);
        w0 = write_count;
        applyStimulus(OP_ADD, 2'd0, 2'd1, 2'd3, 1'b0);
        repeat (3) @(negedge clock);
        checkOutput("abort_wb_write", 32'(bus.write), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("abort_write", 32'(bus.write), 32'd0);
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_done", 32'(bus.done), 32'd0);
        checkOutput("abort_result", bus.result, 32'd0);
        checkOutput("abort_wrdata", bus.wrData, 32'd0);
        checkOutput("abort_wrreg", 32'(bus.wrreg), 32'd0);
        checkOutput("abort_rdreg1", 32'(bus.rdreg1), 32'd0);
        checkOutput("abort_rdreg2", 32'(bus.rdreg2), 32'd0);
        checkOutput("abort_ready", 32'(bus.cmd_ready), 32'd0);
        @(negedge clock);
        checkOutput("abort_rf", rf[3], 32'hFFFF_FFFF);
        checkOutput("abort_no_done", 32'(bus.done), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("abort_ready_after", 32'(bus.cmd_ready), 32'd1);
        checkOutput("abort_no_write", 32'(write_count - w0), 32'd0);

        // Random commands against the model
        $display("[TB] random commands");
        preload(32'd5, 32'd3, 32'd0, 32'hFFFF_FFFF);
        w0 = write_count;
        a0 = accept_count;
        for (int n = 0; n < 1000; n++) begin
            runCmd(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        end
        @(negedge clock);
        for (int i = 0; i < 4; i++) checkOutput("rand_rf", rf[i], model[i]);
        checkOutput("rand_writes", 32'(write_count - w0), 32'd1000);
        checkOutput("rand_accepts", 32'(accept_count - a0), 32'd1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
